// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: filtered receiver, set-2 prefix decoder, key-held map and event FIFO.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses repeated identical make events.
module ps2_key_tracker #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h174, 9'h16B, 9'h172, 9'h175},
  parameter int                    FIFO_DEPTH     = 8,
  parameter int                    FILTER_LEN     = 8,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [9:0]          evt_data,
  output logic                frame_err,
  output logic                overflow
);
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} pfx_t;

  logic           ps2c_m_q, ps2c_s_q, ps2d_m_q, ps2d_s_q;
  logic [FCW-1:0] fcnt_q;
  logic           filt_q, fall_q, bit_q;
  logic [3:0]     bitcnt_q;
  logic [9:0]     frame_q;
  logic [TCW-1:0] tcnt_q;
  logic           byte_vld_q, frame_err_q;
  logic [7:0]     byte_q;
  pfx_t           state_q;
  logic [NUM_KEYS-1:0] held_q;
  logic [9:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           evt_valid_q, overflow_q;
  logic [9:0]     evt_data_q, head_d;
  logic           is_e0_s, is_f0_s, is_e1_s, evt_fire_s, evt_ext_s, evt_brk_s;
  logic           repeat_s, push_s, pop_s, full_s, wr_en_s;
  logic [9:0]     evt_s;

  // Pin synchronisers and the glitch filter; a filtered falling edge captures the data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2c_m_q <= 1'b1; ps2c_s_q <= 1'b1; ps2d_m_q <= 1'b1; ps2d_s_q <= 1'b1;
      fcnt_q   <= '0;   filt_q   <= 1'b1; fall_q   <= 1'b0; bit_q    <= 1'b1;
    end else begin
      ps2c_m_q <= ps2_clk;  ps2c_s_q <= ps2c_m_q;
      ps2d_m_q <= ps2_data; ps2d_s_q <= ps2d_m_q;
      fall_q   <= 1'b0;
      if (ps2c_s_q != filt_q) begin
        if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
          filt_q <= ps2c_s_q;
          fcnt_q <= '0;
          fall_q <= ~ps2c_s_q;
          bit_q  <= ps2d_s_q;
        end else begin
          fcnt_q <= fcnt_q + FCW'(1);
        end
      end else begin
        fcnt_q <= '0;
      end
    end
  end

  // Frame assembly: frame_q[0]=start, [8:1]=data, [9]=parity; the stop bit is checked live.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt_q <= 4'd0; frame_q <= 10'd0; tcnt_q <= '0;
      byte_vld_q <= 1'b0; byte_q <= 8'd0; frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall_q) begin
        tcnt_q <= '0;
        if (bitcnt_q == 4'd10) begin
          bitcnt_q <= 4'd0;
          if (!frame_q[0] && (^frame_q[9:1]) && bit_q) begin
            byte_vld_q <= 1'b1;
            byte_q     <= frame_q[8:1];
          end else begin
            frame_err_q <= 1'b1;
          end
        end else begin
          frame_q  <= {bit_q, frame_q[9:1]};
          bitcnt_q <= bitcnt_q + 4'd1;
        end
      end else if (bitcnt_q != 4'd0) begin
        if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          tcnt_q      <= '0;
          bitcnt_q    <= 4'd0;
          frame_err_q <= 1'b1;
        end else begin
          tcnt_q <= tcnt_q + TCW'(1);
        end
      end else begin
        tcnt_q <= '0;
      end
    end
  end

  always_comb begin
    is_e0_s    = (byte_q == 8'hE0);
    is_f0_s    = (byte_q == 8'hF0);
    is_e1_s    = (byte_q == 8'hE1);
    evt_fire_s = byte_vld_q && !is_e0_s && !is_f0_s && !is_e1_s;
    evt_ext_s  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    evt_brk_s  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    evt_s      = {evt_ext_s, evt_brk_s, byte_q};
  end

  // Prefix decoder; any receive error drops a half-built prefix.
  always_ff @(posedge clk) begin
    if (rst || frame_err_q) begin
      state_q <= ST_IDLE;
    end else if (byte_vld_q) begin
      if (is_e0_s) begin
        state_q <= ST_EXT;
      end else if (is_f0_s) begin
        case (state_q)
          ST_IDLE: state_q <= ST_BRK;
          ST_EXT:  state_q <= ST_EXT_BRK;
          default: state_q <= state_q;
        endcase
      end else begin
        state_q <= ST_IDLE;
      end
    end else begin
      state_q <= state_q;
    end
  end

  // Held bits follow every decoded event, whether or not the FIFO takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= '0;
    end else if (evt_fire_s) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (KEY_CODES[9*i +: 9] == {evt_ext_s, byte_q}) held_q[i] <= ~evt_brk_s;
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       last_vld_q;
  logic [8:0] last_code_q;

  // Remembers the last make so auto-repeat of the same key is not queued again.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_vld_q <= 1'b0; last_code_q <= 9'd0;
    end else if (evt_fire_s) begin
      last_vld_q  <= ~evt_brk_s;
      last_code_q <= {evt_ext_s, byte_q};
    end
  end

  assign repeat_s = !evt_brk_s && last_vld_q && (last_code_q == {evt_ext_s, byte_q});
`else
  assign repeat_s = 1'b0;
`endif

  assign push_s  = evt_fire_s && !repeat_s;
  assign pop_s   = evt_valid_q && evt_ready;
  assign full_s  = (cnt_q == CW'(FIFO_DEPTH));
  assign wr_en_s = push_s && (!full_s || pop_s);

  // Next occupancy and next head word, so evt_data can be registered.
  always_comb begin
    case ({wr_en_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (cnt_d == CW'(0))        head_d = 10'd0;
    else if (pop_s)             head_d = (cnt_q == CW'(1)) ? evt_s : mem_q[rd_q + AW'(1)];
    else if (cnt_q == CW'(0))   head_d = evt_s;
    else                        head_d = evt_data_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) mem_q[wr_q] <= evt_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0; rd_q <= '0; cnt_q <= '0;
      evt_valid_q <= 1'b0; evt_data_q <= 10'd0; overflow_q <= 1'b0;
    end else begin
      if (wr_en_s) wr_q <= wr_q + AW'(1);
      if (pop_s)   rd_q <= rd_q + AW'(1);
      cnt_q       <= cnt_d;
      evt_valid_q <= (cnt_d != CW'(0));
      evt_data_q  <= head_d;
      if (push_s && full_s && !pop_s) overflow_q <= 1'b1;
    end
  end

  assign key_held  = held_q;
  assign evt_valid = evt_valid_q;
  assign evt_data  = evt_data_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios plus random key traffic
// compared against an event-level model of the keyboard, key map and queue.
module tb_ps2_key_tracker;
  localparam int FL    = 4;
  localparam int TO    = 2000;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, evt_ready;
  logic [3:0] key_held;
  logic       evt_valid, frame_err, overflow;
  logic [9:0] evt_data;

  ps2_key_tracker #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_held(key_held), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_data(evt_data), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ferr_cnt = 0;
  always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

  int checks = 0;
  int errors = 0;

  // Reference model: event queue, held keys, sticky overflow, last make.
  logic [9:0] mq [$];
  logic [3:0] m_held;
  logic       m_ovf;
  logic       m_last_vld;
  logic [8:0] m_last;
  logic [8:0] kc [4] = '{9'h175, 9'h172, 9'h16B, 9'h174};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " key_held"}, 32'(key_held), 32'(m_held));
    chk({tag, " evt_valid"}, 32'(evt_valid), 32'(mq.size() != 0));
    chk({tag, " evt_data"}, 32'(evt_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic model_reset();
    mq.delete(); m_held = 4'd0; m_ovf = 1'b0; m_last_vld = 1'b0; m_last = 9'd0;
  endtask

  task automatic model_event(input logic ext, input logic brk, input logic [7:0] code);
    bit push;
    for (int i = 0; i < 4; i++) if (kc[i] == {ext, code}) m_held[i] = ~brk;
    push = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (!brk && m_last_vld && m_last == {ext, code}) push = 1'b0;
    m_last_vld = ~brk;
    m_last     = {ext, code};
`endif
    if (push) begin
      if (mq.size() == DEPTH) m_ovf = 1'b1;
      else mq.push_back({ext, brk, code});
    end
  endtask

  // mode 0: plain; 1: pop in the cycle of the push; 2: check latency into an empty FIFO.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits,
                           input int mode, input logic [9:0] t2exp, input bit glitch);
    logic [10:0] f;
    int hp, t;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    hp = 16;
    for (int k = 0; k < nbits; k++) begin
      hp = $urandom_range(14, 20);
      @(negedge clk); ps2_data = f[k];
      if (glitch && k == 3) begin
        ps2_clk = 1'b0; repeat (2) @(negedge clk); ps2_clk = 1'b1;
      end
      repeat (hp) @(negedge clk);
      ps2_clk = 1'b0;
      if (k == 10 && mode != 0) begin
        t = cyc + 2 + FL;
        while (cyc < t + 1) @(negedge clk);
        if (mode == 1) begin
          chk("prepop valid", 32'(evt_valid), 32'd1);
          chk("prepop data", 32'(evt_data), 32'(mq[0]));
          evt_ready = 1'b1;
          void'(mq.pop_front());
          @(negedge clk);
          evt_ready = 1'b0;
        end else begin
          chk("T+1 valid", 32'(evt_valid), 32'd0);
          @(negedge clk);
          chk("T+2 valid", 32'(evt_valid), 32'd1);
          chk("T+2 data", 32'(evt_data), 32'(t2exp));
        end
      end
      repeat (hp) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (hp) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    send_bits(b, bad_par, 11, 0, 10'd0, 1'b0);
  endtask

  task automatic send_event(input logic ext, input logic brk, input logic [7:0] code,
                            input int mode, input bit glitch);
    if (ext) send_frame(8'hE0, 1'b0);
    if (brk) send_frame(8'hF0, 1'b0);
    send_bits(code, 1'b0, 11, mode, {ext, brk, code}, glitch);
    model_event(ext, brk, code);
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    chk({tag, " pop valid"}, 32'(evt_valid), 32'd1);
    chk({tag, " pop data"}, 32'(evt_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    check_state({tag, " after pop"});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  logic [7:0] ovf_codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

  initial begin
    int f0;
    logic       ext, brk;
    logic [7:0] code;
    int         r;

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b0;
    model_reset();
    do_reset();
    check_state("reset");
    chk("reset frame_err", 32'(frame_err), 32'd0);

    // Up arrow make then break.
    send_event(1'b1, 1'b0, 8'h75, 2, 1'b0);
    check_state("up make");
    pop_check("up make");
    send_event(1'b1, 1'b1, 8'h75, 2, 1'b0);
    check_state("up break");
    pop_check("up break");

    // Left and right held together, drained in order.
    send_event(1'b1, 1'b0, 8'h6B, 0, 1'b0);
    send_event(1'b1, 1'b0, 8'h74, 0, 1'b0);
    check_state("two makes");
    pop_check("two makes a");
    pop_check("two makes b");

    // Parity error, then a good frame.
    f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1);
    chk("parity frame_err", 32'(ferr_cnt), 32'(f0 + 1));
    check_state("parity no event");
    send_event(1'b0, 1'b0, 8'h1C, 2, 1'b0);
    pop_check("after parity");

    // Overflow, then a push coinciding with a pop while full.
    for (int i = 0; i < 9; i++) send_event(1'b0, 1'b0, ovf_codes[i], 0, 1'b0);
    check_state("overflow");
    send_event(1'b0, 1'b0, 8'h4D, 1, 1'b0);
    check_state("full push+pop");
    while (mq.size() != 0) pop_check("drain ovf");

    // Timeout mid-frame, then a good frame.
    do_reset();
    check_state("reset 2");
    f0 = ferr_cnt;
    send_bits(8'hA5, 1'b0, 7, 0, 10'd0, 1'b0);
    repeat (TO + 50) @(negedge clk);
    chk("timeout frame_err", 32'(ferr_cnt), 32'(f0 + 1));
    send_event(1'b0, 1'b0, 8'h1C, 2, 1'b0);
    pop_check("after timeout");

    // Auto-repeat sequence.
    do_reset();
    for (int i = 0; i < 3; i++) send_event(1'b1, 1'b0, 8'h75, 0, 1'b0);
    send_event(1'b1, 1'b1, 8'h75, 0, 1'b0);
    send_event(1'b1, 1'b0, 8'h75, 0, 1'b0);
    check_state("typematic");
    while (mq.size() != 0) pop_check("drain typematic");

    // Reset mid-frame and mid-prefix.
    send_bits(8'h75, 1'b0, 5, 0, 10'd0, 1'b0);
    do_reset();
    check_state("reset mid-frame");
    send_frame(8'hE0, 1'b0);
    do_reset();
    send_event(1'b0, 1'b0, 8'h75, 2, 1'b0);
    pop_check("after mid-prefix reset");

    // Random traffic.
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 5);
      if (r < 3) begin
        r = $urandom_range(0, 3);
        ext = kc[r][8]; code = kc[r][7:0];
      end else begin
        ext = 1'($urandom_range(0, 1));
        do code = 8'($urandom_range(0, 255)); while (code == 8'hE0 || code == 8'hF0 || code == 8'hE1);
      end
      brk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) send_frame(8'hE1, 1'b0);
      if ($urandom_range(0, 7) == 0) begin
        f0 = ferr_cnt;
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        chk("rand bad frame", 32'(ferr_cnt), 32'(f0 + 1));
      end
      if (ext) send_frame(8'hE0, 1'b0);
      if (brk) send_frame(8'hF0, 1'b0);
      if (brk && $urandom_range(0, 2) == 0) send_frame(8'hF0, 1'b0);
      send_bits(code, 1'b0, 11, 0, 10'd0, 1'($urandom_range(0, 1)));
      model_event(ext, brk, code);
      check_state("random");
      if (mq.size() != 0 && ($urandom_range(0, 2) == 0 || mq.size() >= 6)) pop_check("random");
    end
    while (mq.size() != 0) pop_check("final drain");
    check_state("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
